// File: rtl/regfile_hilo_pkg.sv
// Shared layout of the writeback-to-register-file bus.
package regfile_hilo_pkg;

  localparam int unsigned WB_TO_RF_WD    = 38;
  localparam int unsigned WB_TO_RF_BUS_W = WB_TO_RF_WD + 64 + 1;

  localparam int unsigned INST_DIV_BIT = 102;
  localparam int unsigned DIV_HI_MSB   = 101;
  localparam int unsigned DIV_LO_MSB   = 69;
  localparam int unsigned RF_WE_BIT    = 37;
  localparam int unsigned RF_WADDR_MSB = 36;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// HI/LO register pair written on divide commit.
// RF_WB_BYPASS_EN makes the read outputs show the incoming divide result in the same cycle.
module hilo_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inst_div,
  input  logic [DATA_W-1:0] i_div_hi,
  input  logic [DATA_W-1:0] i_div_lo,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_inst_div) begin
      r_hi <= i_div_hi;
      r_lo <= i_div_lo;
    end
  end

`ifdef RF_WB_BYPASS_EN
  always_comb begin
    o_hi = r_hi;
    o_lo = r_lo;
    if (i_inst_div) begin
      o_hi = i_div_hi;
      o_lo = i_div_lo;
    end
  end
`else
  always_comb begin
    o_hi = r_hi;
    o_lo = r_lo;
  end
`endif

endmodule

// File: rtl/regfile_hilo.sv
// GPR file (r0 reads zero) and HI/LO pair committed from the WB bus.
// RF_WB_BYPASS_EN turns the read ports into write-through ports.
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WB_TO_RF_BUS_W-1:0] wb_to_rf_bus,
  input  logic [ADDR_W-1:0]         raddr1,
  output logic [DATA_W-1:0]         rdata1,
  input  logic [ADDR_W-1:0]         raddr2,
  output logic [DATA_W-1:0]         rdata2,
  output logic [DATA_W-1:0]         hi_rdata,
  output logic [DATA_W-1:0]         lo_rdata,
  output logic [31:0]               wr_count
);

  logic              w_inst_div;
  logic [DATA_W-1:0] w_div_hi;
  logic [DATA_W-1:0] w_div_lo;
  logic              w_rf_we;
  logic [ADDR_W-1:0] w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_gpr_wr;

  assign w_inst_div = wb_to_rf_bus[INST_DIV_BIT];
  assign w_div_hi   = wb_to_rf_bus[DIV_HI_MSB -: DATA_W];
  assign w_div_lo   = wb_to_rf_bus[DIV_LO_MSB -: DATA_W];
  assign w_rf_we    = wb_to_rf_bus[RF_WE_BIT];
  assign w_rf_waddr = wb_to_rf_bus[RF_WADDR_MSB -: ADDR_W];
  assign w_rf_wdata = wb_to_rf_bus[DATA_W-1:0];

  // Writes to r0 are discarded and not counted.
  assign w_gpr_wr = w_rf_we && (w_rf_waddr != REG_ZERO);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [31:0]       r_wr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_gpr_wr) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
      r_wr_count         <= r_wr_count + 32'd1;
    end
  end

  assign wr_count = r_wr_count;

  always_comb begin
    rdata1 = (raddr1 == REG_ZERO) ? '0 : r_regs[raddr1];
    rdata2 = (raddr2 == REG_ZERO) ? '0 : r_regs[raddr2];
`ifdef RF_WB_BYPASS_EN
    if (w_gpr_wr && (w_rf_waddr == raddr1)) begin
      rdata1 = w_rf_wdata;
    end
    if (w_gpr_wr && (w_rf_waddr == raddr2)) begin
      rdata2 = w_rf_wdata;
    end
`endif
  end

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo_reg (
    .clk        (clk),
    .rst        (rst),
    .i_inst_div (w_inst_div),
    .i_div_hi   (w_div_hi),
    .i_div_lo   (w_div_lo),
    .o_hi       (hi_rdata),
    .o_lo       (lo_rdata)
  );

endmodule
